// File: rtl/inst_loader_if.sv
// Shared types plus the loader bus: byte-stream input side and the
// instruction-memory load port that the loader drives.
package inst_loader_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] inst_t;

    localparam addr_t       InstStartFrom = 32'h0000_0000;
    localparam int unsigned InstSpace     = 32'h0000_1000;
endpackage

interface inst_loader_if;
    import inst_loader_pkg::*;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    addr_t      addr;
    inst_t      load_inst;
    logic       load;
    logic       chip_select;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, addr, load_inst, load, chip_select
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, addr, load_inst, load, chip_select
    );
endinterface

// File: rtl/inst_loader.sv
// Boot-time instruction loader: length header, LSB-first words, one write per word.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter addr_t       START_ADDR = InstStartFrom,
    parameter int unsigned MAX_WORDS  = InstSpace >> 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    inst_loader_if.master     bus,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_FINISH = S_CSUM;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    state_t      state_reg, state_next;
    logic [15:0] len_reg;
    logic [15:0] word_cnt_reg;
    logic [1:0]  byte_idx_reg;
    logic [7:0]  asm_reg [3];
    addr_t       addr_reg;
    inst_t       load_inst_reg;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_reg;
`endif

    logic        accept;
    logic        idle_like;
    logic [15:0] len_full;

    // Every output is a decode of registered state, so byte_ready never sees byte_valid.
    assign idle_like       = (state_reg == S_IDLE) || (state_reg == S_DONE) || (state_reg == S_ERR);
    assign bus.byte_ready  = (state_reg == S_LEN_LO) || (state_reg == S_LEN_HI) ||
                             (state_reg == S_DATA)   || (state_reg == S_CSUM);
    assign busy            = !idle_like;
    assign bus.chip_select = !idle_like;
    assign bus.load        = (state_reg == S_WRITE);
    assign done            = (state_reg == S_DONE);
    assign error           = (state_reg == S_ERR);
    assign bus.addr        = addr_reg;
    assign bus.load_inst   = load_inst_reg;

    assign accept   = bus.byte_valid && bus.byte_ready;
    assign len_full = {bus.byte_data, len_reg[7:0]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) begin
                    if (len_full == 16'd0)
                        state_next = S_FINISH;
                    else if ({16'd0, len_full} > MAX_WORDS)
                        state_next = S_ERR;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && byte_idx_reg == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                if (word_cnt_reg + 16'd1 == len_reg)
                    state_next = S_FINISH;
                else
                    state_next = S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) state_next = (bus.byte_data == csum_reg) ? S_DONE : S_ERR;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            len_reg       <= '0;
            word_cnt_reg  <= '0;
            byte_idx_reg  <= '0;
            addr_reg      <= START_ADDR;
            load_inst_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (start && idle_like) begin
                len_reg      <= '0;
                word_cnt_reg <= '0;
                byte_idx_reg <= '0;
                addr_reg     <= START_ADDR;
            end
            if (accept) begin
                if (state_reg == S_LEN_LO) len_reg[7:0]  <= bus.byte_data;
                if (state_reg == S_LEN_HI) len_reg[15:8] <= bus.byte_data;
                if (state_reg == S_DATA) begin
                    byte_idx_reg <= byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3)
                        load_inst_reg <= {bus.byte_data, asm_reg[2], asm_reg[1], asm_reg[0]};
                end
            end
            if (state_reg == S_WRITE) begin
                word_cnt_reg <= word_cnt_reg + 16'd1;
                addr_reg     <= addr_reg + 32'd4;
            end
        end
    end

    // Lower three bytes of a word wait here until the fourth byte completes it.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_asm
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    asm_reg[gi] <= '0;
                else if (accept && state_reg == S_DATA && byte_idx_reg == 2'(gi))
                    asm_reg[gi] <= bus.byte_data;
            end
        end
    endgenerate

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            csum_reg <= '0;
        else if (start && idle_like)
            csum_reg <= '0;
        else if (accept)
            csum_reg <= csum_reg ^ bus.byte_data;
    end
`endif

endmodule
